// File: rtl/rgb888_to_rgb332_quantizer.sv
// rgb888_to_rgb332_quantizer
// Streaming RGB888 -> RGB332 converter with pixel position tracking and
// line/frame boundary tags. Output packing: [7:6]=blue, [5:3]=green, [2:0]=red.
// Two register stages: stage 1 holds the raw pixel and its tags, stage 2 holds
// the quantized word. Both stages advance together on en = !m_valid || m_ready.
// Optional ordered (4x4 Bayer) dithering is enabled by defining RGB332_DITHER_EN;
// without it the rounding offset is a constant 128 and no dither logic exists.
module rgb888_to_rgb332_quantizer #(
  parameter int H_ACTIVE = 600,
  parameter int V_ACTIVE = 450
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_sof,
  input  logic [23:0] s_rgb,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_rgb,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_eof
);

  // Counters are at least 2 bits wide so the dither index bits always exist.
  localparam int XW = (H_ACTIVE > 4) ? $clog2(H_ACTIVE) : 2;
  localparam int YW = (V_ACTIVE > 4) ? $clog2(V_ACTIVE) : 2;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic          en;
  logic          accept;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic          pix_eol;
  logic          pix_ylast;

  logic          s1_valid;
  logic [23:0]   s1_rgb;
  logic          s1_sof;
  logic          s1_eol;
  logic          s1_eof;

  logic [7:0]    t;
  logic [2:0]    q_r;
  logic [2:0]    q_g;
  logic [1:0]    q_b;

  // No skid buffer: the input is ready exactly when the pipeline can advance.
  assign en      = !m_valid || m_ready;
  assign s_ready = en;
  assign accept  = s_valid && en;

  // Position of the pixel being presented and the position that follows it;
  // an accepted s_sof forces the pixel to (0,0) regardless of the counters.
  always_comb begin
    pix_x     = s_sof ? '0 : x;
    pix_y     = s_sof ? '0 : y;
    pix_eol   = (pix_x == X_LAST);
    pix_ylast = (pix_y == Y_LAST);
    next_x    = pix_x + XW'(1);
    next_y    = pix_y;
    if (pix_eol) begin
      next_x = '0;
      next_y = pix_ylast ? '0 : (pix_y + YW'(1));
    end
  end

  // Position counters move only when a pixel is actually accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      x <= next_x;
      y <= next_y;
    end
  end

`ifdef RGB332_DITHER_EN
  logic [1:0] s1_px;
  logic [1:0] s1_py;
  logic [3:0] bayer;

  // Stage 1 dither index: low two bits of the pixel's tagged position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_px <= '0;
      s1_py <= '0;
    end else if (en) begin
      s1_px <= pix_x[1:0];
      s1_py <= pix_y[1:0];
    end
  end

  // 4x4 Bayer matrix lookup; offset t = bayer*16 + 8 spans 8..248.
  always_comb begin
    bayer = 4'd0;
    case ({s1_py, s1_px})
      4'h0: bayer = 4'd0;
      4'h1: bayer = 4'd8;
      4'h2: bayer = 4'd2;
      4'h3: bayer = 4'd10;
      4'h4: bayer = 4'd12;
      4'h5: bayer = 4'd4;
      4'h6: bayer = 4'd14;
      4'h7: bayer = 4'd6;
      4'h8: bayer = 4'd3;
      4'h9: bayer = 4'd11;
      4'hA: bayer = 4'd1;
      4'hB: bayer = 4'd9;
      4'hC: bayer = 4'd15;
      4'hD: bayer = 4'd7;
      4'hE: bayer = 4'd13;
      default: bayer = 4'd5;
    endcase
    t = {bayer, 4'b1000};
  end
`else
  assign t = 8'd128;
`endif

  // Stage 1: capture pixel and the boundary tags of its own position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_rgb   <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else if (en) begin
      s1_valid <= s_valid;
      s1_rgb   <= s_rgb;
      s1_sof   <= (pix_x == '0) && (pix_y == '0);
      s1_eol   <= pix_eol;
      s1_eof   <= pix_eol && pix_ylast;
    end
  end

  // Rounded scaling q = (v*N + t) >> 8; sums never exceed 11 (R,G) / 10 (B) bits.
  assign q_r = 3'(({3'b000, s1_rgb[23:16]} * 11'd7 + {3'b000, t}) >> 8);
  assign q_g = 3'(({3'b000, s1_rgb[15:8]}  * 11'd7 + {3'b000, t}) >> 8);
  assign q_b = 2'(({2'b00,  s1_rgb[7:0]}   * 10'd3 + {2'b00,  t}) >> 8);

  // Stage 2: quantized output word; tags are only asserted on valid pixels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_rgb   <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
    end else if (en) begin
      m_valid <= s1_valid;
      m_rgb   <= {q_b, q_g, q_r};
      m_sof   <= s1_valid && s1_sof;
      m_eol   <= s1_valid && s1_eol;
      m_eof   <= s1_valid && s1_eof;
    end
  end

endmodule

// File: doc/rgb888_to_rgb332_quantizer.md
Name: rgb888_to_rgb332_quantizer

Overview:
- Streaming pixel converter. Accepts 24-bit RGB888 pixels, for example from a host image loader or a test pattern source, and emits 8-bit RGB332 words in the same packing the palette/NTSC path consumes: rgb[7:6]=blue, rgb[5:3]=green, rgb[2:0]=red.
- It is the inverse of the 332-to-888 expansion (q*255/N, N=7 for red and green, N=3 for blue). Expanding a 332 code then re-quantizing it returns the original code exactly.
- Tracks pixel position and tags line and frame boundaries.

Parameters:
- H_ACTIVE, 600, active pixels per line
- V_ACTIVE, 450, active lines per frame

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- s_valid  in  1  input pixel valid
- s_ready  out  1  input accepted when s_valid && s_ready
- s_sof  in  1  qualifies the accepted pixel as frame start, position (0,0)
- s_rgb  in  24  [23:16]=R8, [15:8]=G8, [7:0]=B8
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_rgb  out  8  RGB332 pixel
- m_sof  out  1  output pixel is (0,0)
- m_eol  out  1  output pixel is x==H_ACTIVE-1
- m_eof  out  1  output pixel is (H_ACTIVE-1, V_ACTIVE-1)

Behaviour:
- Reset (rst_n low at a clk edge):
  - m_valid, m_rgb, m_sof, m_eol and m_eof all go to 0.
  - x and y counters go to 0.
  - Pipeline contents are discarded, including a reset asserted mid-frame.
- Reset value of s_ready: s_ready is combinational (below). While rst_n is low it evaluates to 1, because m_valid is 0.
- Pipeline:
  - Two register stages. Stage 1 captures pixel, position and flags. Stage 2 holds the quantized output.
  - Latency is 2 clk from acceptance to m_valid.
  - Throughput is 1 pixel/clk.
- Advance enable:
  - en = !m_valid || m_ready.
  - s_ready = en. This is combinational from m_ready; there is no skid buffer.
  - When en=0, both stages hold. m_rgb and the flags stay stable while m_valid=1 && !m_ready.
  - Stage valid bits propagate on en. A bubble (s_valid=0) propagates as m_valid=0.
- Position counters (advance on accept only):
  - If s_sof is accepted: that pixel is tagged (0,0); next x=1, y=0.
  - Else: the pixel takes the current (x,y).
  - x wraps to 0 after H_ACTIVE-1 and increments y.
  - y wraps to 0 after V_ACTIVE-1.
  - Flags derive from the pixel's own position: m_sof = (0,0); m_eol = x==H_ACTIVE-1; m_eof = m_eol && y==V_ACTIVE-1.
  - An s_sof mid-frame restarts the position with no error indication.
- Quantization (per channel, unsigned, no saturation needed):
  - q = (v*N + t) >> 8, with N=7 for R and G, N=3 for B.
  - Widths: v*7 is 11 bits; v*7+t is at most 2033, so the result fits in 3 bits. v*3+t is at most 1013, so the result fits in 2 bits.
  - t = 128 when the optional feature is absent.
- Round-trip check: every q*255/7 (q=0..7) and q*255/3 (q=0..3) maps back to q.

Optional Feature:
- Macro: RGB332_DITHER_EN.
- When defined:
  - t = bayer[y&3][x&3]*16 + 8, using the pixel's tagged position.
  - Bayer rows: {0,8,2,10}, {12,4,14,6}, {3,11,1,9}, {15,7,13,5}.
  - t ranges from 8 to 248.
  - The same t applies to all three channels.
  - Round-trip identity is not required in this mode.
- When undefined: t = 128 constant, and no dither logic is synthesized.

Test Plan:
- Reset then flat s_rgb=0xFFFFFF, s_valid=1, m_ready=1 -> m_valid first high on the 2nd clk after accept; m_rgb=0xFF every pixel.
- Round trip, dither off: feed all 256 expanded 332 codes, e.g. R8=0x24, G8=0x00, B8=0x55 -> m_rgb=0x41. Also R8=0x12 -> red 0; R8=0x13 -> red 1.
- Framing with H_ACTIVE=4, V_ACTIVE=2, s_sof on the first pixel, 8 pixels:
  - m_sof on pixel 0 only.
  - m_eol on pixels 3 and 7.
  - m_eof on pixel 7.
  - 9th pixel without s_sof -> m_sof=1 (counters wrapped).
- Backpressure: hold m_ready=0 for 3 clk mid-stream -> s_ready=0; m_rgb/m_valid/flags stable; no pixel lost or duplicated after release.
- Mid-frame reset: rst_n low 1 clk with 2 pixels in flight -> m_valid=0 next cycle; counters restart at (0,0).
- Flat s_rgb=0x808080:
  - Dither off -> m_rgb=0xA4 for all pixels.
  - RGB332_DITHER_EN -> pixel (0,0)=0x5B, pixel (1,0)=0xA4.
